// File: rtl/kband_out_streamer_if.sv
// Streaming bus bundle for kband_out_streamer: FIFO read side plus the
// valid/ready packet side toward the host interface.
// master = the streamer, slave = the FIFO / sink environment.
interface kband_out_streamer_if #(
    parameter int DATA_W = 128
);
    logic [DATA_W-1:0] fifo_q;
    logic              fifo_rdempty;
    logic              fifo_rdreq;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_sop;
    logic              st_eop;

    modport master (
        input  fifo_q, fifo_rdempty, st_ready,
        output fifo_rdreq, st_data, st_valid, st_sop, st_eop
    );

    modport slave (
        output fifo_q, fifo_rdempty, st_ready,
        input  fifo_rdreq, st_data, st_valid, st_sop, st_eop
    );
endinterface

// File: rtl/kband_out_streamer.sv
// kband_out_streamer: drains the K-band output FIFO (normal read mode,
// 1-cycle read latency) into one SOP/EOP-framed valid/ready packet per
// alignment. Reads are throttled against a 3-entry skid buffer so the
// read request never depends combinationally on st_ready.
// Optional feature macro: KBAND_OUT_CHECKSUM_EN appends an XOR checksum beat.
module kband_out_streamer #(
    parameter int DATA_W = 128,
    parameter int LEN_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [LEN_W-1:0] cfg_beats,
    output logic             busy,
    output logic             done,
    kband_out_streamer_if.master bus
);

`ifdef KBAND_OUT_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, STREAM, CSUM} state_t;
`else
    typedef enum logic [1:0] {IDLE, STREAM} state_t;
`endif

    localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t                      state;
    logic [LEN_W-1:0]            issued;
    logic [LEN_W-1:0]            sent;
    logic [LEN_W-1:0]            len;
    logic [1:0]                  occ;
    logic                        inflight;
    logic [2:0][DATA_W-1:0]      skid;
    logic [2:0][DATA_W-1:0]      skid_nxt;
    logic [2:0]                  fill;
    logic [1:0]                  wr_idx;
    logic                        rdreq;
    logic                        pay_valid;
    logic                        pay_hs;
    logic                        last;
`ifdef KBAND_OUT_CHECKSUM_EN
    logic [DATA_W-1:0]           csum;
`endif

    // Beats held plus the one possibly returning from the FIFO bound the next read.
    assign fill      = {1'b0, occ} + {2'b00, inflight};
    assign rdreq     = (state == STREAM) && !bus.fifo_rdempty && (issued < len) && (fill < 3'd3);
    assign pay_valid = (state == STREAM) && (occ != 2'd0);
    assign pay_hs    = pay_valid && bus.st_ready;
    assign last      = (sent == len - ONE);
    assign wr_idx    = occ - {1'b0, pay_hs};

    assign bus.fifo_rdreq = rdreq;
    assign bus.st_sop     = pay_valid && (sent == '0);
`ifdef KBAND_OUT_CHECKSUM_EN
    assign bus.st_valid   = pay_valid || (state == CSUM);
    assign bus.st_eop     = (state == CSUM);
    assign bus.st_data    = (state == CSUM) ? csum : skid[0];
`else
    assign bus.st_valid   = pay_valid;
    assign bus.st_eop     = pay_valid && last;
    assign bus.st_data    = skid[0];
`endif

    // Skid buffer next value: shift toward the head on pop, land returning data behind the survivors.
    always_comb begin
        skid_nxt = skid;
        if (pay_hs) begin
            skid_nxt[0] = skid[1];
            skid_nxt[1] = skid[2];
        end
        if (inflight) begin
            skid_nxt[wr_idx] = bus.fifo_q;
        end
    end

    // Control FSM, counters and skid buffer storage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            issued   <= '0;
            sent     <= '0;
            len      <= '0;
            occ      <= 2'd0;
            inflight <= 1'b0;
            skid     <= '0;
`ifdef KBAND_OUT_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            done     <= 1'b0;
            inflight <= rdreq;
            occ      <= occ + {1'b0, inflight} - {1'b0, pay_hs};
            skid     <= skid_nxt;
            if (rdreq)  issued <= issued + ONE;
            if (pay_hs) sent   <= sent + ONE;
`ifdef KBAND_OUT_CHECKSUM_EN
            if (pay_hs) csum   <= csum ^ skid[0];
`endif
            case (state)
                IDLE: begin
                    // Zero-length requests never open a packet.
                    if (start && (cfg_beats != '0)) begin
                        state  <= STREAM;
                        busy   <= 1'b1;
                        len    <= cfg_beats;
                        issued <= '0;
                        sent   <= '0;
`ifdef KBAND_OUT_CHECKSUM_EN
                        csum   <= '0;
`endif
                    end
                end
                STREAM: begin
                    if (pay_hs && last) begin
`ifdef KBAND_OUT_CHECKSUM_EN
                        state <= CSUM;
`else
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end
                end
`ifdef KBAND_OUT_CHECKSUM_EN
                CSUM: begin
                    if (bus.st_ready) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kband_out_streamer.sv
// Bench for kband_out_streamer: FIFO modelled as an array with read/write
// pointers (normal read mode), packet expectations built from the list of
// payload beats pushed, plus an XOR beat when the checksum build is enabled.
module tb_kband_out_streamer;
    localparam int DW = 128;
    localparam int LW = 16;
`ifdef KBAND_OUT_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] cfg_beats = '0;
    logic          busy;
    logic          done;

    kband_out_streamer_if #(.DATA_W(DW)) bus ();

    kband_out_streamer #(.DATA_W(DW), .LEN_W(LW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .cfg_beats (cfg_beats),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // FIFO model
    logic [DW-1:0] fmem [0:1023];
    int wptr = 0;
    int rptr = 0;
    assign bus.fifo_rdempty = (wptr == rptr);
    always @(posedge clk) begin
        if (bus.fifo_rdreq) begin
            bus.fifo_q <= fmem[rptr % 1024];
            rptr <= rptr + 1;
        end
    end

    task automatic push_beat(input logic [DW-1:0] d);
        fmem[wptr % 1024] = d;
        wptr = wptr + 1;
    endtask

    // Sink ready pattern: 0 = always ready, 1 = toggle, 2 = random
    int rdy_mode = 0;
    initial bus.st_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       bus.st_ready = 1'b1;
            1:       bus.st_ready = ~bus.st_ready;
            default: bus.st_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Sink monitor
    logic [DW-1:0] rd_data [$];
    bit            rd_sop  [$];
    bit            rd_eop  [$];
    int nrdreq = 0, ndone = 0, stab_err = 0, bad_rd = 0, idle_busy = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] pdata;
    logic          psop, peop;
    always @(negedge clk) begin
        if (!reset_n) begin
            prev_stall = 0;
        end else begin
            if (bus.fifo_rdreq) nrdreq++;
            if (bus.fifo_rdreq && bus.fifo_rdempty) bad_rd++;
            if (done) ndone++;
            if (busy && !bus.st_valid) idle_busy++;
            if (prev_stall && (!bus.st_valid || bus.st_data !== pdata ||
                               bus.st_sop !== psop || bus.st_eop !== peop)) stab_err++;
            if (bus.st_valid && bus.st_ready) begin
                rd_data.push_back(bus.st_data);
                rd_sop.push_back(bus.st_sop);
                rd_eop.push_back(bus.st_eop);
            end
            prev_stall = bus.st_valid && !bus.st_ready;
            pdata = bus.st_data;
            psop  = bus.st_sop;
            peop  = bus.st_eop;
        end
    end

    logic [DW-1:0] pay [$];

    function automatic logic [DW-1:0] rnd();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic clr_mon();
        rd_data.delete(); rd_sop.delete(); rd_eop.delete();
        nrdreq = 0; ndone = 0; stab_err = 0; bad_rd = 0; idle_busy = 0;
    endtask

    task automatic pulse_start(input int n);
        @(posedge clk); #1;
        start = 1'b1; cfg_beats = LW'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string lbl);
        int cyc = 0;
        while (ndone == 0 && cyc < 600) begin
            @(negedge clk); #1;
            cyc++;
        end
        checks++;
        if (ndone == 0) begin
            errors++;
            $display("FAIL %s done timeout: got none within %0d cycles, need 1", lbl, cyc);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic check_pkt(input string lbl, input int n);
        logic [DW-1:0] exp [$];
        logic [DW-1:0] x;
        int m;
        exp = pay;
        x = '0;
        foreach (pay[i]) x = x ^ pay[i];
`ifdef KBAND_OUT_CHECKSUM_EN
        exp.push_back(x);
`endif
        checks++;
        if (rd_data.size() !== exp.size()) begin
            errors++;
            $display("FAIL %s beat count: got %0d need %0d", lbl, rd_data.size(), exp.size());
        end
        m = (rd_data.size() < exp.size()) ? rd_data.size() : exp.size();
        for (int i = 0; i < m; i++) begin
            checks++;
            if (rd_data[i] !== exp[i]) begin
                errors++;
                $display("FAIL %s beat%0d data: got %h need %h", lbl, i, rd_data[i], exp[i]);
            end
            checks++;
            if (rd_sop[i] !== (i == 0)) begin
                errors++;
                $display("FAIL %s beat%0d sop: got %0b need %0b", lbl, i, rd_sop[i], (i == 0));
            end
            checks++;
            if (rd_eop[i] !== (i == exp.size() - 1)) begin
                errors++;
                $display("FAIL %s beat%0d eop: got %0b need %0b", lbl, i, rd_eop[i], (i == exp.size() - 1));
            end
        end
        checks++;
        if (nrdreq !== n) begin
            errors++;
            $display("FAIL %s rdreq count: got %0d need %0d", lbl, nrdreq, n);
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL %s done pulses: got %0d need 1", lbl, ndone);
        end
        checks++;
        if (stab_err !== 0) begin
            errors++;
            $display("FAIL %s stall stability: got %0d violations need 0", lbl, stab_err);
        end
        checks++;
        if (bad_rd !== 0) begin
            errors++;
            $display("FAIL %s rdreq while empty: got %0d need 0", lbl, bad_rd);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy after done: got %0b need 0", lbl, busy);
        end
    endtask

    // Push the payload (optionally only the first two beats up front), run one packet, check it.
    task automatic run_pkt(input string lbl, input bit gap);
        int n = pay.size();
        int pre = gap ? 2 : n;
        clr_mon();
        for (int i = 0; i < pre; i++) push_beat(pay[i]);
        pulse_start(n);
        if (gap) begin
            repeat (8) @(posedge clk);
            #1;
            for (int i = pre; i < n; i++) push_beat(pay[i]);
        end
        wait_done(lbl);
        check_pkt(lbl, n);
    endtask

    task automatic check_idle_outputs(input string lbl);
        checks++;
        if ({bus.fifo_rdreq, bus.st_valid, bus.st_sop, bus.st_eop, busy, done} !== 6'b0 ||
            bus.st_data !== '0) begin
            errors++;
            $display("FAIL %s outputs: got rdreq=%0b valid=%0b sop=%0b eop=%0b busy=%0b done=%0b data=%h need all 0",
                     lbl, bus.fifo_rdreq, bus.st_valid, bus.st_sop, bus.st_eop, busy, done, bus.st_data);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Fixed cycle-by-cycle timing of a 4-beat packet with an always-ready sink.
    task automatic test_basic();
        bit e_rd, e_v, e_sop, e_eop, e_done, e_busy;
        logic [DW-1:0] e_d;
        rdy_mode = 0;
        clr_mon();
        for (int i = 1; i <= 4; i++) push_beat(DW'(i));
        @(posedge clk); #1;
        start = 1'b1; cfg_beats = LW'(4);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 8 + CS; k++) begin
            @(negedge clk);
            e_rd   = (k >= 1 && k <= 4);
            e_v    = (k >= 3 && k <= 6 + CS);
            e_sop  = (k == 3);
            e_eop  = (k == 6 + CS);
            e_done = (k == 7 + CS);
            e_busy = (k <= 6 + CS);
            e_d    = (k <= 6) ? DW'(k - 2) : DW'(1 ^ 2 ^ 3 ^ 4);
            checks++;
            if ({bus.fifo_rdreq, bus.st_valid, bus.st_sop, bus.st_eop, done, busy} !==
                {e_rd, e_v, e_sop, e_eop, e_done, e_busy}) begin
                errors++;
                $display("FAIL basic cycle%0d ctrl rd/v/sop/eop/done/busy: got %b need %b", k,
                         {bus.fifo_rdreq, bus.st_valid, bus.st_sop, bus.st_eop, done, busy},
                         {e_rd, e_v, e_sop, e_eop, e_done, e_busy});
            end
            if (e_v) begin
                checks++;
                if (bus.st_data !== e_d) begin
                    errors++;
                    $display("FAIL basic cycle%0d data: got %h need %h", k, bus.st_data, e_d);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        rdy_mode = 1;
        pay.delete();
        for (int i = 0; i < 8; i++) pay.push_back(rnd());
        run_pkt("toggle8", 1'b0);
        rdy_mode = 0;
    endtask

    task automatic test_empty_gap();
        rdy_mode = 0;
        pay.delete();
        for (int i = 0; i < 6; i++) pay.push_back(rnd());
        run_pkt("gap6", 1'b1);
        checks++;
        if (idle_busy < 7) begin
            errors++;
            $display("FAIL gap6 valid gap: got %0d busy-idle cycles need >= 7", idle_busy);
        end
    endtask

    task automatic test_ignored_start();
        rdy_mode = 0;
        clr_mon();
        pulse_start(0);
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || ndone !== 0) begin
            errors++;
            $display("FAIL zero_start: got busy=%0b done_count=%0d need 0/0", busy, ndone);
        end
        pay.delete();
        for (int i = 0; i < 5; i++) pay.push_back(rnd());
        clr_mon();
        foreach (pay[i]) push_beat(pay[i]);
        push_beat(rnd());
        push_beat(rnd());
        pulse_start(5);
        @(posedge clk); #1;
        start = 1'b1; cfg_beats = LW'(2);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("busy_start");
        check_pkt("busy_start", 5);
        wptr = rptr;
    endtask

    task automatic test_reset_mid();
        rdy_mode = 0;
        pay.delete();
        for (int i = 0; i < 10; i++) pay.push_back(rnd());
        clr_mon();
        foreach (pay[i]) push_beat(pay[i]);
        pulse_start(10);
        repeat (3) @(posedge clk);
        #2;
        reset_n = 1'b0;
        wptr = rptr;
        #1;
        check_idle_outputs("reset_mid");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        pay.delete();
        pay.push_back(rnd());
        pay.push_back(rnd());
        run_pkt("after_reset2", 1'b0);
    endtask

    task automatic test_random();
        rdy_mode = 2;
        for (int p = 0; p < 5; p++) begin
            int n = $urandom_range(1, 12);
            pay.delete();
            for (int i = 0; i < n; i++) pay.push_back(rnd());
            run_pkt($sformatf("rand%0d", p), 1'b0);
        end
        rdy_mode = 0;
    endtask

    task automatic test_checksum();
        rdy_mode = 0;
        pay.delete();
        pay.push_back(DW'(8'hF0));
        pay.push_back(DW'(8'h0F));
        pay.push_back(DW'(8'hFF));
        run_pkt("f0_0f_ff", 1'b0);
`ifdef KBAND_OUT_CHECKSUM_EN
        checks++;
        if (rd_data.size() !== 4) begin
            errors++;
            $display("FAIL csum beats: got %0d need 4", rd_data.size());
        end else begin
            checks++;
            if (rd_data[3] !== '0 || rd_eop[3] !== 1'b1 || rd_eop[2] !== 1'b0) begin
                errors++;
                $display("FAIL csum beat: got data=%h eop3=%0b eop2=%0b need 0/1/0",
                         rd_data[3], rd_eop[3], rd_eop[2]);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        repeat (3) @(negedge clk);
        test_backpressure();
        test_empty_gap();
        test_ignored_start();
        test_reset_mid();
        test_random();
        test_checksum();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
